parking_payment_ctrl: RTL and testbench
=======================================

// Module: parking_payment_ctrl
// PURPOSE
//  Exit-side payment controller placed directly upstream of the 4-slot parking top level.
//  It consumes the top level's fee_ready and fee outputs and produces the payment_received input
//  that releases the exit gate and triggers billing.
//  It accumulates coin/card credit, settles against the latched fee, returns change, and refunds on cancel or timeout.
// PARAMETERS
//  FEE_W        32    width of fee, credit and change values (matches top-level fee bus)
//  COIN_W        8    width of one coin/credit value
//  TIMEOUT_CYC  1000  idle cycles without a coin in COLLECT before auto-refund (>=2)
// PORTS
//  clk             in   1      single system clock, all logic on rising edge
//  rst             in   1      synchronous, active-low reset (sampled on clk rising edge)
//  fee_ready       in   1      level from parking FSM: exit car waiting to pay
//  fee             in   FEE_W  amount due; valid whenever fee_ready=1
//  coin_valid      in   1      one-cycle strobe: coin_value accepted this cycle
//  coin_value      in   COIN_W credit value of strobed coin
//  cancel          in   1      one-cycle strobe: driver aborts payment
//  payment_received out 1      one-cycle pulse: fee fully covered
//  change_valid    out  1      one-cycle pulse, coincident with payment_received
//  change_amount   out  FEE_W  paid_total-amount_due; held until next session
//  refund_valid    out  1      one-cycle pulse: session aborted, credit returned
//  refund_amount   out  FEE_W  credit returned; held until next session
//  coin_reject     out  1      one-cycle pulse: coin strobed outside COLLECT, returned
//  timeout_err     out  1      one-cycle pulse, coincident with refund_valid when cause is timeout
//  amount_due      out  FEE_W  latched fee of current session
//  paid_total      out  FEE_W  credit accumulated in current session
//  busy            out  1      high in every state except IDLE
// BEHAVIOUR
//  Reset (rst=0 at edge): state=IDLE; every output 0; timeout counter 0. Reset wins over all inputs, any state.
//  All outputs registered. States: IDLE, COLLECT, SETTLE, REFUND, DONE.
//  IDLE: fee_ready=1 -> amount_due<=fee, paid_total<=0, change/refund_amount<=0.
//    If fee=0 -> SETTLE, else COLLECT.
//  COLLECT: coin_valid -> paid_total<=sat(paid_total+zext(coin_value)), saturating at 2^FEE_W-1.
//    Timeout counter cleared on entry and on every coin.
//    Exit priority, evaluated on next-value paid_total:
//    (1) total>=amount_due -> SETTLE;
//    (2) cancel | fee_ready=0 -> REFUND;
//    (3) counter reaches TIMEOUT_CYC-1 with no coin -> REFUND, timeout_err.
//    Coin and cancel in the same cycle: coin counted first; settling coin beats cancel.
//  SETTLE (1 cycle): payment_received=1, change_valid=1, change_amount=paid_total-amount_due -> DONE.
//    Latency: qualifying coin sampled at edge N; pulses are high in cycle N+1.
//  REFUND (1 cycle): refund_valid=1, refund_amount=paid_total (0 allowed) -> IDLE.
//    If fee_ready is still 1, IDLE re-latches on the next edge as a new session.
//  DONE: hold, wait for fee_ready=0 -> IDLE. Prevents double payment on a long fee_ready level.
//  coin_valid in IDLE/SETTLE/REFUND/DONE: no credit; coin_reject pulse in the following cycle.
//  cancel outside COLLECT: ignored.
//  fee changes while busy: ignored (amount_due is latched).
//  Pulse outputs never exceed one cycle. payment_received and refund_valid are never both high.
// STRUCTURE
//  Shared package parking_pkg: FEE_W default, state encoding localparams
//    (PAY_IDLE, PAY_COLLECT, PAY_SETTLE, PAY_REFUND, PAY_DONE),
//    and saturating-add function sat_add.
//  One sub-module: pay_timeout_timer (clear, enable, TIMEOUT_CYC param -> expired pulse),
//    counter width $clog2(TIMEOUT_CYC).
//  Top module holds FSM, accumulator and output registers.
// TESTING
//  1 Exact pay: fee=20, coins 10,10 -> payment_received one cycle after 2nd coin,
//    change_amount=0, paid_total=20.
//  2 Overpay: fee=15, coin 20 -> payment_received and change_valid same cycle, change_amount=5.
//    DONE held until fee_ready=0.
//  3 Cancel: fee=30, coin 10, cancel -> refund_valid, refund_amount=10, no payment_received.
//    fee_ready still 1 -> new session, paid_total=0.
//  4 Timeout: TIMEOUT_CYC=8, fee=5, no coins -> refund_valid + timeout_err 8 cycles after entering COLLECT,
//    refund_amount=0.
//  5 Corners: fee=0 -> payment_received 1 cycle after latch;
//    coin in IDLE -> coin_reject, paid_total 0;
//    coin 5 + cancel same cycle with fee=5 -> settle wins;
//    saturation with FEE_W=8 (paid_total clamps at 255).
//  6 Reset: rst=0 mid-COLLECT with paid_total=7 -> next cycle IDLE, all outputs 0, no refund pulse.
//    Also run in loop with the parking top level: exit_gate opens after payment.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared definitions for the parking exit payment path.
//   FEE_W    : default width of fee, credit and change values
//   pay_state_t : payment controller state encoding
//   sat_add  : unsigned add that clamps at 2^w-1 (w <= 64)
package parking_pkg;

  localparam int FEE_W = 32;

  typedef enum logic [2:0] {
    PAY_IDLE    = 3'd0,
    PAY_COLLECT = 3'd1,
    PAY_SETTLE  = 3'd2,
    PAY_REFUND  = 3'd3,
    PAY_DONE    = 3'd4
  } pay_state_t;

  // Operands are zero-extended into 64 bits by the caller. The result is
  // clamped to the largest w-bit value, so the caller can truncate safely.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << w) - 65'd1;
    return (sum > lim) ? lim[63:0] : sum[63:0];
  endfunction

endpackage

// File: rtl/pay_timeout_timer.sv
// Idle timer for the COLLECT state.
//   clk, rst : clock, synchronous active-low reset
//   clear    : restart the count at 0 (takes priority over enable)
//   enable   : advance the count by one per cycle
//   expired  : high in the cycle the count sits at TIMEOUT_CYC-1 while
//              enabled and not being cleared
module pay_timeout_timer #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: registers are updated with non-blocking assignments so every
  // always_ff reads the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/parking_payment_ctrl.sv
// Exit-side payment controller. Latches the fee presented by the parking
// FSM, accumulates coin/card credit, and either settles (payment_received +
// change) or refunds the credit on cancel, fee_ready drop or idle timeout.
//   fee_ready/fee          : exit car waiting, amount due
//   coin_valid/coin_value  : one-cycle credit strobe
//   cancel                 : one-cycle abort strobe (COLLECT only)
//   payment_received, change_valid, change_amount : settlement result
//   refund_valid, refund_amount, timeout_err      : abort result
//   coin_reject            : coin offered outside COLLECT was returned
//   amount_due, paid_total, busy                  : session status
// All outputs are registered.
module parking_payment_ctrl
  import parking_pkg::*;
#(
  parameter int FEE_W       = parking_pkg::FEE_W,
  parameter int COIN_W      = 8,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fee_ready,
  input  logic [FEE_W-1:0]  fee,
  input  logic              coin_valid,
  input  logic [COIN_W-1:0] coin_value,
  input  logic              cancel,
  output logic              payment_received,
  output logic              change_valid,
  output logic [FEE_W-1:0]  change_amount,
  output logic              refund_valid,
  output logic [FEE_W-1:0]  refund_amount,
  output logic              coin_reject,
  output logic              timeout_err,
  output logic [FEE_W-1:0]  amount_due,
  output logic [FEE_W-1:0]  paid_total,
  output logic              busy
);

  pay_state_t       state, state_next;
  logic [FEE_W-1:0] paid_next;
  logic             timeout_hit;
  logic             expired;
  logic             in_collect;

  assign in_collect = (state == PAY_COLLECT);

  // Restart on entry (any non-COLLECT cycle) and on every accepted coin.
  pay_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (!in_collect || coin_valid),
    .enable (in_collect),
    .expired(expired)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    paid_next   = paid_total;
    timeout_hit = 1'b0;

    if (in_collect && coin_valid) begin
      paid_next = FEE_W'(sat_add(64'(paid_total), 64'(coin_value), FEE_W));
    end

    case (state)
      PAY_IDLE: begin
        if (fee_ready) begin
          state_next = (fee == '0) ? PAY_SETTLE : PAY_COLLECT;
        end
      end
      PAY_COLLECT: begin
        // Settle is judged on the post-coin total, so a covering coin wins
        // over a cancel or fee_ready drop in the same cycle.
        if (paid_next >= amount_due) begin
          state_next = PAY_SETTLE;
        end else if (cancel || !fee_ready) begin
          state_next = PAY_REFUND;
        end else if (expired) begin
          state_next  = PAY_REFUND;
          timeout_hit = 1'b1;
        end
      end
      PAY_SETTLE: state_next = PAY_DONE;
      PAY_REFUND: state_next = PAY_IDLE;
      PAY_DONE: begin
        if (!fee_ready) begin
          state_next = PAY_IDLE;
        end
      end
      default: state_next = PAY_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= PAY_IDLE;
      payment_received <= 1'b0;
      change_valid     <= 1'b0;
      change_amount    <= '0;
      refund_valid     <= 1'b0;
      refund_amount    <= '0;
      coin_reject      <= 1'b0;
      timeout_err      <= 1'b0;
      amount_due       <= '0;
      paid_total       <= '0;
      busy             <= 1'b0;
    end else begin
      state            <= state_next;
      // SETTLE and REFUND last exactly one cycle, so these stay single pulses.
      payment_received <= (state_next == PAY_SETTLE);
      change_valid     <= (state_next == PAY_SETTLE);
      refund_valid     <= (state_next == PAY_REFUND);
      timeout_err      <= timeout_hit;
      coin_reject      <= coin_valid && !in_collect;
      busy             <= (state_next != PAY_IDLE);

      if (state == PAY_IDLE && fee_ready) begin
        amount_due    <= fee;
        paid_total    <= '0;
        change_amount <= '0;
        refund_amount <= '0;
      end else begin
        paid_total <= paid_next;
      end

      if (in_collect && state_next == PAY_SETTLE) begin
        change_amount <= paid_next - amount_due;
      end
      if (in_collect && state_next == PAY_REFUND) begin
        refund_amount <= paid_next;
      end
    end
  end

endmodule

// File: tb/tb_parking_payment_ctrl.sv
module tb_parking_payment_ctrl;

  typedef struct packed {
    logic        fr;
    logic [31:0] fee;
    logic        cv;
    logic [7:0]  coin;
    logic        cancel;
  } in_t;

  typedef struct packed {
    logic        pay;
    logic        chg_v;
    logic [31:0] chg;
    logic        ref_v;
    logic [31:0] ref_amt;
    logic        rej;
    logic        tmo;
    logic [31:0] due;
    logic [31:0] paid;
    logic        busy;
  } out_t;

  typedef struct packed {
    in_t  in;
    out_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        fee_ready;
  logic [31:0] fee;
  logic        coin_valid;
  logic [7:0]  coin_value;
  logic        cancel;

  logic        payment_received, change_valid, refund_valid;
  logic        coin_reject, timeout_err, busy;
  logic [31:0] change_amount, refund_amount, amount_due, paid_total;

  logic       p8_pay, p8_chg_v, p8_ref_v, p8_rej, p8_tmo, p8_busy;
  logic [7:0] p8_chg, p8_ref, p8_due, p8_paid;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  parking_payment_ctrl #(.FEE_W(32), .COIN_W(8), .TIMEOUT_CYC(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .fee_ready       (fee_ready),
    .fee             (fee),
    .coin_valid      (coin_valid),
    .coin_value      (coin_value),
    .cancel          (cancel),
    .payment_received(payment_received),
    .change_valid    (change_valid),
    .change_amount   (change_amount),
    .refund_valid    (refund_valid),
    .refund_amount   (refund_amount),
    .coin_reject     (coin_reject),
    .timeout_err     (timeout_err),
    .amount_due      (amount_due),
    .paid_total      (paid_total),
    .busy            (busy)
  );

  // Narrow instance used for the saturation corner.
  parking_payment_ctrl #(.FEE_W(8), .COIN_W(8), .TIMEOUT_CYC(8)) dut8 (
    .clk             (clk),
    .rst             (rst),
    .fee_ready       (fee_ready),
    .fee             (fee[7:0]),
    .coin_valid      (coin_valid),
    .coin_value      (coin_value),
    .cancel          (cancel),
    .payment_received(p8_pay),
    .change_valid    (p8_chg_v),
    .change_amount   (p8_chg),
    .refund_valid    (p8_ref_v),
    .refund_amount   (p8_ref),
    .coin_reject     (p8_rej),
    .timeout_err     (p8_tmo),
    .amount_due      (p8_due),
    .paid_total      (p8_paid),
    .busy            (p8_busy)
  );

  function automatic out_t actual();
    return '{pay: payment_received, chg_v: change_valid, chg: change_amount,
             ref_v: refund_valid, ref_amt: refund_amount, rej: coin_reject,
             tmo: timeout_err, due: amount_due, paid: paid_total, busy: busy};
  endfunction

  function automatic vec_t mk(logic fr, int unsigned f, logic cv, int unsigned c,
                              logic can, logic pay, logic chg_v, int unsigned chg,
                              logic ref_v, int unsigned ref_amt, logic rej,
                              logic tmo, int unsigned due, int unsigned paid,
                              logic bsy);
    vec_t v;
    v.in  = '{fr: fr, fee: f, cv: cv, coin: c[7:0], cancel: can};
    v.exp = '{pay: pay, chg_v: chg_v, chg: chg, ref_v: ref_v, ref_amt: ref_amt,
              rej: rej, tmo: tmo, due: due, paid: paid, busy: bsy};
    return v;
  endfunction

  task automatic check(input string name, input logic [159:0] act,
                       input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input in_t i);
    fee_ready  = i.fr;
    fee        = i.fee;
    coin_valid = i.cv;
    coin_value = i.coin;
    cancel     = i.cancel;
  endtask

  vec_t tbl[$];
  int   edges;
  logic tmo_seen;
  logic pay_seen;

  initial begin
    // fr fee cv coin can | pay chgv chg refv ref rej tmo due paid busy
    // Exact pay: fee 20, coins 10 + 10
    tbl.push_back(mk(1,20,0, 0,0, 0,0,0, 0, 0,0,0,20, 0,1));
    tbl.push_back(mk(1,20,1,10,0, 0,0,0, 0, 0,0,0,20,10,1));
    tbl.push_back(mk(1,20,1,10,0, 1,1,0, 0, 0,0,0,20,20,1));
    tbl.push_back(mk(1,20,0, 0,0, 0,0,0, 0, 0,0,0,20,20,1));
    tbl.push_back(mk(1,20,0, 0,0, 0,0,0, 0, 0,0,0,20,20,1));
    tbl.push_back(mk(0, 0,0, 0,0, 0,0,0, 0, 0,0,0,20,20,0));
    // Overpay: fee 15, coin 20 -> change 5; DONE held, coin there rejected
    tbl.push_back(mk(1,15,0, 0,0, 0,0,0, 0, 0,0,0,15, 0,1));
    tbl.push_back(mk(1,15,1,20,0, 1,1,5, 0, 0,0,0,15,20,1));
    tbl.push_back(mk(1,15,0, 0,0, 0,0,5, 0, 0,0,0,15,20,1));
    tbl.push_back(mk(1,15,1, 3,0, 0,0,5, 0, 0,1,0,15,20,1));
    tbl.push_back(mk(1,15,0, 0,0, 0,0,5, 0, 0,0,0,15,20,1));
    tbl.push_back(mk(0, 0,0, 0,0, 0,0,5, 0, 0,0,0,15,20,0));
    // Cancel: fee 30, coin 10, cancel -> refund 10, then new session
    tbl.push_back(mk(1,30,0, 0,0, 0,0,0, 0, 0,0,0,30, 0,1));
    tbl.push_back(mk(1,30,1,10,0, 0,0,0, 0, 0,0,0,30,10,1));
    tbl.push_back(mk(1,30,0, 0,1, 0,0,0, 1,10,0,0,30,10,1));
    tbl.push_back(mk(1,30,0, 0,0, 0,0,0, 0,10,0,0,30,10,0));
    tbl.push_back(mk(1,30,0, 0,0, 0,0,0, 0, 0,0,0,30, 0,1));
    // fee_ready drop in COLLECT -> zero refund
    tbl.push_back(mk(0, 0,0, 0,0, 0,0,0, 1, 0,0,0,30, 0,1));
    tbl.push_back(mk(0, 0,0, 0,0, 0,0,0, 0, 0,0,0,30, 0,0));
    // Settling coin and cancel together: settle wins
    tbl.push_back(mk(1, 5,0, 0,0, 0,0,0, 0, 0,0,0, 5, 0,1));
    tbl.push_back(mk(1, 5,1, 5,1, 1,1,0, 0, 0,0,0, 5, 5,1));
    tbl.push_back(mk(0, 0,0, 0,0, 0,0,0, 0, 0,0,0, 5, 5,1));
    tbl.push_back(mk(0, 0,0, 0,0, 0,0,0, 0, 0,0,0, 5, 5,0));
    // Zero fee settles straight from IDLE
    tbl.push_back(mk(1, 0,0, 0,0, 1,1,0, 0, 0,0,0, 0, 0,1));
    tbl.push_back(mk(0, 0,0, 0,0, 0,0,0, 0, 0,0,0, 0, 0,1));
    tbl.push_back(mk(0, 0,0, 0,0, 0,0,0, 0, 0,0,0, 0, 0,0));
    // Coin in IDLE rejected; cancel in IDLE ignored
    tbl.push_back(mk(0, 0,1, 9,0, 0,0,0, 0, 0,1,0, 0, 0,0));
    tbl.push_back(mk(0, 0,0, 0,0, 0,0,0, 0, 0,0,0, 0, 0,0));
    tbl.push_back(mk(0, 0,0, 0,1, 0,0,0, 0, 0,0,0, 0, 0,0));

    rst = 1'b0;
    drive('0);
    step();
    step();
    check("reset_outputs", 160'(actual()), 160'(out_t'('0)));
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].in);
      step();
      check($sformatf("vec%0d", i), 160'(actual()), 160'(tbl[i].exp));
    end
    drive('0);

    // Timeout with no coins: refund 8 edges after entering COLLECT.
    fee_ready = 1'b1;
    fee = 32'd5;
    step();
    edges = 0;
    tmo_seen = 1'b0;
    pay_seen = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (payment_received) pay_seen = 1'b1;
      if (refund_valid) begin
        edges = k;
        tmo_seen = timeout_err;
        break;
      end
    end
    check("timeout_latency", 160'(edges), 160'(8));
    check("timeout_err", 160'(tmo_seen), 160'(1));
    check("timeout_refund_amt", 160'(refund_amount), 160'(0));
    check("timeout_no_pay", 160'(pay_seen), 160'(0));
    fee_ready = 1'b0;
    step();
    step();

    // A coin restarts the idle count.
    fee_ready = 1'b1;
    step();
    for (int k = 0; k < 5; k++) step();
    coin_valid = 1'b1;
    coin_value = 8'd1;
    step();
    coin_valid = 1'b0;
    edges = 0;
    tmo_seen = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (refund_valid) begin
        edges = k;
        tmo_seen = timeout_err;
        break;
      end
    end
    check("timeout_after_coin", 160'(edges), 160'(8));
    check("timeout_after_coin_err", 160'(tmo_seen), 160'(1));
    check("timeout_after_coin_amt", 160'(refund_amount), 160'(1));
    fee_ready = 1'b0;
    step();
    step();

    // Reset in the middle of COLLECT with 7 credited.
    fee_ready = 1'b1;
    fee = 32'd20;
    step();
    coin_valid = 1'b1;
    coin_value = 8'd7;
    step();
    check("pre_reset_paid", 160'(paid_total), 160'(7));
    rst = 1'b0;
    cancel = 1'b1;
    coin_value = 8'd50;
    step();
    check("reset_mid_collect", 160'(actual()), 160'(out_t'('0)));
    rst = 1'b1;
    cancel = 1'b0;
    coin_valid = 1'b0;
    fee_ready = 1'b0;
    step();
    check("post_reset_quiet", 160'({refund_valid, busy, payment_received}), 160'(0));

    // Saturation on the 8-bit instance: 200 + 200 clamps at 255.
    fee_ready = 1'b1;
    fee = 32'd255;
    step();
    coin_valid = 1'b1;
    coin_value = 8'd200;
    step();
    check("sat8_first", 160'(p8_paid), 160'(200));
    step();
    coin_valid = 1'b0;
    check("sat8_clamp", 160'({p8_pay, p8_chg_v, p8_paid, p8_chg}),
          160'({1'b1, 1'b1, 8'd255, 8'd0}));
    check("sat32_no_clamp", 160'({payment_received, paid_total, change_amount}),
          160'({1'b1, 32'd400, 32'd145}));
    fee_ready = 1'b0;
    step();
    step();
    check("final_idle", 160'({busy, p8_busy}), 160'(0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
